// File: rtl/hx_key_pkg.sv
// hx_key_pkg: key indices, key polarity and debounce constants shared by key_cond,
// the counter top-level and its bench.
package hx_key_pkg;
   localparam int   KEY_EN_IDX   = 2;
   localparam int   KEY_LOAD_IDX = 1;
   localparam int   KEY_RST_IDX  = 0;
   localparam logic KEY_PRESSED  = 1'b0;
   localparam int   DEB_20MS_50M = 1_000_000;
   function automatic int deb_cnt_w(input int cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-FF synchronizer plus counter debouncer for one active-low key,
// with registered press/release pulses.
module debounce_cell
   import hx_key_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_20MS_50M
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic stable_o,
   output logic press_o,
   output logic release_o,
   output logic press_evt_o
);
   localparam int            CW      = deb_cnt_w(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
   logic          s1_q, s2_q, stable_q, stable_d, press_q, press_d, rel_q, rel_d, accept;
   logic [CW-1:0] cnt_q, cnt_d;
   // accept fires on the edge that completes DEB_CYCLES consecutive mismatching samples
   always_comb begin
      accept   = (s2_q != stable_q) && (cnt_q == CNT_MAX);
      cnt_d    = (s2_q == stable_q || accept) ? '0 : cnt_q + CW'(1);
      stable_d = accept ? s2_q : stable_q;
      press_d  = accept && (s2_q == KEY_PRESSED);
      rel_d    = accept && (s2_q != KEY_PRESSED);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         s1_q     <= key_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
      end
   end
   assign stable_o    = stable_q;
   assign press_o     = press_q;
   assign release_o   = rel_q;
   assign press_evt_o = press_d;
endmodule

// File: rtl/key_cond.sv
// key_cond: conditions three raw pushbuttons into debounced levels, press/release
// pulses and the KEY bus of the counter stage, with KEY[2] as a press-toggled enable.
module key_cond
   import hx_key_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_20MS_50M
) (
   input  logic       CLK_50,
   input  logic       RST_N,
   input  logic [2:0] KEY_IN,
   output logic [2:0] KEY_OUT,
   output logic [2:0] STABLE,
   output logic [2:0] PRESS,
   output logic [2:0] RELEASE
);
   logic [2:0] press_evt;
   logic       en_q, en_d;
   genvar i;
   for (i = 0; i < 3; i++) begin : g_key
      debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_cell (
         .clk_i      (CLK_50),
         .rst_ni     (RST_N),
         .key_i      (KEY_IN[i]),
         .stable_o   (STABLE[i]),
         .press_o    (PRESS[i]),
         .release_o  (RELEASE[i]),
         .press_evt_o(press_evt[i])
      );
   end
   // toggle on the same edge that registers PRESS[2]
   assign en_d = en_q ^ press_evt[KEY_EN_IDX];
   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) en_q <= 1'b0;
      else        en_q <= en_d;
   end
   assign KEY_OUT[KEY_EN_IDX]   = en_q;
   assign KEY_OUT[KEY_LOAD_IDX] = STABLE[KEY_LOAD_IDX];
   assign KEY_OUT[KEY_RST_IDX]  = STABLE[KEY_RST_IDX];
endmodule

// File: tb/tb_key_cond.sv
// tb_key_cond: table-driven scoreboard bench for key_cond with DEB_CYCLES = 4.
module tb_key_cond;
   typedef struct {
      logic        rst_n;
      logic [2:0]  key;
      int          n;
      logic [11:0] e;
   } step_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  key_in = 3'b000;
   logic [2:0]  key_out, stable, press, rel;
   int          n_vec = 0;
   int          n_bad = 0;
   step_t       steps[$];
   logic [11:0] exp_q[$];
   key_cond #(.DEB_CYCLES(4)) dut (
      .CLK_50 (clk),
      .RST_N  (rst_n),
      .KEY_IN (key_in),
      .KEY_OUT(key_out),
      .STABLE (stable),
      .PRESS  (press),
      .RELEASE(rel)
   );
   always #1 clk = ~clk;
   function automatic step_t st(input logic r, input logic [2:0] k, input int n,
                                input logic [2:0] ko, input logic [2:0] sb,
                                input logic [2:0] pr, input logic [2:0] rl);
      st.rst_n = r;
      st.key   = k;
      st.n     = n;
      st.e     = {ko, sb, pr, rl};
   endfunction
   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got key_out=%b stable=%b press=%b release=%b, want key_out=%b stable=%b press=%b release=%b",
                  nm, act[11:9], act[8:6], act[5:3], act[2:0], exp[11:9], exp[8:6], exp[5:3], exp[2:0]);
      end
   endtask
   function automatic logic [11:0] outs();
      return {key_out, stable, press, rel};
   endfunction
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end
   initial begin
      int at;
      // reset with all keys low, then all-key press/release
      steps.push_back(st(0, 3'b000, 3,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b000, 5,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b000, 1,  3'b100, 3'b000, 3'b111, 3'b000));
      steps.push_back(st(1, 3'b000, 3,  3'b100, 3'b000, 3'b000, 3'b000));
      steps.push_back(st(0, 3'b111, 2,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 2,  3'b011, 3'b111, 3'b000, 3'b000));
      // clean press/release of key 1
      steps.push_back(st(1, 3'b101, 5,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b101, 1,  3'b001, 3'b101, 3'b010, 3'b000));
      steps.push_back(st(1, 3'b101, 14, 3'b001, 3'b101, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 5,  3'b001, 3'b101, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 1,  3'b011, 3'b111, 3'b000, 3'b010));
      steps.push_back(st(1, 3'b111, 4,  3'b011, 3'b111, 3'b000, 3'b000));
      // bounce on key 0: lows of 1, 2, 3 cycles then steady low
      steps.push_back(st(1, 3'b110, 1,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 1,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b110, 2,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 1,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b110, 3,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 1,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b110, 5,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b110, 1,  3'b010, 3'b110, 3'b001, 3'b000));
      steps.push_back(st(1, 3'b110, 4,  3'b010, 3'b110, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 5,  3'b010, 3'b110, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 1,  3'b011, 3'b111, 3'b000, 3'b001));
      steps.push_back(st(1, 3'b111, 4,  3'b011, 3'b111, 3'b000, 3'b000));
      // EN toggle: two full press/release sequences on key 2
      steps.push_back(st(1, 3'b011, 5,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b011, 1,  3'b111, 3'b011, 3'b100, 3'b000));
      steps.push_back(st(1, 3'b011, 4,  3'b111, 3'b011, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 5,  3'b111, 3'b011, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 1,  3'b111, 3'b111, 3'b000, 3'b100));
      steps.push_back(st(1, 3'b111, 4,  3'b111, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b011, 5,  3'b111, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b011, 1,  3'b011, 3'b011, 3'b100, 3'b000));
      steps.push_back(st(1, 3'b011, 4,  3'b011, 3'b011, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 5,  3'b011, 3'b011, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b111, 1,  3'b011, 3'b111, 3'b000, 3'b100));
      steps.push_back(st(1, 3'b111, 4,  3'b011, 3'b111, 3'b000, 3'b000));
      // simultaneous press of all keys
      steps.push_back(st(1, 3'b000, 5,  3'b011, 3'b111, 3'b000, 3'b000));
      steps.push_back(st(1, 3'b000, 1,  3'b100, 3'b000, 3'b111, 3'b000));
      steps.push_back(st(1, 3'b000, 3,  3'b100, 3'b000, 3'b000, 3'b000));
      foreach (steps[s]) begin
         for (int r = 0; r < steps[s].n; r++) begin
            rst_n  = steps[s].rst_n;
            key_in = steps[s].key;
            exp_q.push_back(steps[s].e);
            @(negedge clk);
            chk($sformatf("step%0d.%0d", s, r), outs(), exp_q.pop_front());
         end
      end
      // reset mid-count on key 2
      rst_n  = 1'b0;
      key_in = 3'b111;
      repeat (2) @(negedge clk);
      chk("pre_reset", outs(), {3'b011, 3'b111, 3'b000, 3'b000});
      rst_n  = 1'b1;
      key_in = 3'b011;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("mid_count%0d", c), outs(), {3'b011, 3'b111, 3'b000, 3'b000});
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("in_reset", outs(), {3'b011, 3'b111, 3'b000, 3'b000});
      rst_n = 1'b1;
      at = -1;
      for (int c = 0; c < 20 && at < 0; c++) begin
         @(negedge clk);
         if (press[2]) at = c;
      end
      n_vec++;
      if (at != 5) begin
         n_bad++;
         $display("FAIL reset_press_edge: got edge %0d, want edge 5", at);
      end
      chk("reset_press", outs(), {3'b111, 3'b011, 3'b100, 3'b000});
      @(negedge clk);
      chk("reset_after", outs(), {3'b111, 3'b011, 3'b000, 3'b000});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
